// File: rtl/mod_int_sched.sv
// Prioritised interrupt scheduler: edge capture, mask/pending/cause/EOI registers.
// Optional `MOD_INT_SCHED_RR_EN` selects round-robin instead of fixed priority.
module mod_int_sched #(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ie,
    input  logic             de,
    input  logic [31:0]      iaddr,
    input  logic [31:0]      daddr,
    input  logic [1:0]       drw,
    input  logic [31:0]      din,
    output logic [31:0]      iout,
    output logic [31:0]      dout,
    output logic             int_o,
    input  logic             int_ack,
    input  logic [N_SRC-1:0] i_src
);

    // `int` is a reserved word, so the CPU request leaves as int_o.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC:0]   mask_q, mask_d;
    logic [N_SRC:0]   pend_q, pend_d;
    logic [N_SRC-1:0] prev_q, prev_d;
    logic [4:0]       cause_id_q, cause_id_d;
    logic             int_q;

    logic             wr;
    logic             wr_mask, wr_pend, wr_eoi;
    logic [N_SRC:0]   set_v, clr_v, sel_v, cand;
    logic [4:0]       win_id;
    logic             valid;

    wire unused_in = ^{ie, iaddr, drw[1], din};

    assign wr      = de & drw[0];
    assign wr_mask = wr && (daddr == 32'h0);
    assign wr_pend = wr && (daddr == 32'h4);
    assign wr_eoi  = wr && (daddr == 32'hC);

    assign set_v = {i_src & ~prev_q, 1'b0};
    assign sel_v = (N_SRC+1)'(1) << cause_id_q;
    assign cand  = {pend_q[N_SRC:1] & mask_q[N_SRC:1], 1'b0};

`ifdef MOD_INT_SCHED_RR_EN
    logic [4:0] last_grant_q, last_grant_d;
    logic [4:0] hi_id, lo_id;
    logic       hi_hit;

    // Prefer the lowest candidate above the last grant, else wrap to lowest.
    always_comb begin
        hi_id  = '0;
        lo_id  = '0;
        hi_hit = 1'b0;
        for (int i = N_SRC; i >= 1; i--) begin
            if (cand[i]) begin
                lo_id = 5'(i);
                if (5'(i) > last_grant_q) begin
                    hi_id  = 5'(i);
                    hi_hit = 1'b1;
                end
            end
        end
        win_id = hi_hit ? hi_id : lo_id;
    end
`else
    always_comb begin
        win_id = '0;
        for (int i = N_SRC; i >= 1; i--) begin
            if (cand[i]) win_id = 5'(i);
        end
    end
`endif

    always_comb begin
        mask_d     = mask_q;
        prev_d     = i_src;
        cause_id_d = cause_id_q;
        state_d    = state_q;
        clr_v      = '0;
`ifdef MOD_INT_SCHED_RR_EN
        last_grant_d = last_grant_q;
`endif
        if (wr_mask) mask_d = din[N_SRC:0];
        if (wr_pend) clr_v = din[N_SRC:0];
        if (wr_eoi && state_q == S_SERVICE) clr_v = clr_v | sel_v;
        // A fresh edge wins over any clear of the same bit.
        pend_d = ((pend_q & ~clr_v) | set_v) & ~(N_SRC+1)'(1);

        unique case (state_q)
            S_IDLE: begin
                if (mask_q[0] && |cand) begin
                    cause_id_d = win_id;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (int_ack) begin
                    state_d = S_SERVICE;
`ifdef MOD_INT_SCHED_RR_EN
                    last_grant_d = cause_id_q;
`endif
                end else if (~|(pend_d & sel_v)) begin
                    state_d = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (wr_eoi) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            pend_q     <= '0;
            prev_q     <= '0;
            cause_id_q <= '0;
            int_q      <= 1'b0;
`ifdef MOD_INT_SCHED_RR_EN
            last_grant_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            prev_q     <= prev_d;
            cause_id_q <= cause_id_d;
            int_q      <= (state_d == S_REQ);
`ifdef MOD_INT_SCHED_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign valid = (state_q == S_REQ) || (state_q == S_SERVICE);

    always_comb begin
        dout = '0;
        unique case (daddr)
            32'h0:   dout = 32'(mask_q);
            32'h4:   dout = 32'(pend_q);
            32'h8:   dout = {valid, 26'b0, cause_id_q};
            default: dout = '0;
        endcase
    end

    assign iout  = '0;
    assign int_o = int_q;

endmodule

// File: tb/tb_mod_int_sched.sv
// Directed bench for mod_int_sched with hand-computed expectations.
module tb_mod_int_sched;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ie;
    logic          de;
    logic [31:0]   iaddr;
    logic [31:0]   daddr;
    logic [1:0]    drw;
    logic [31:0]   din;
    logic [31:0]   iout;
    logic [31:0]   dout;
    logic          int_o;
    logic          int_ack;
    logic [N-1:0]  i_src;

    int total = 0;
    int bad   = 0;

    mod_int_sched #(.N_SRC(N)) dut (
        .clk(clk), .rst(rst), .ie(ie), .de(de),
        .iaddr(iaddr), .daddr(daddr), .drw(drw), .din(din),
        .iout(iout), .dout(dout), .int_o(int_o),
        .int_ack(int_ack), .i_src(i_src)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a,
                      input logic [31:0] exp);
        daddr = a;
        #1;
        chk(tag, dout, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        de = 1'b1; drw = 2'b01; daddr = a; din = d;
        tick();
        de = 1'b0; drw = 2'b00; din = '0;
    endtask

    initial begin
        rst = 1'b1; ie = 1'b0; de = 1'b0; iaddr = '0; daddr = '0;
        drw = 2'b00; din = '0; int_ack = 1'b0; i_src = '0;
        tick();
        rst = 1'b0;
        rd("rst_mask", 32'h0, 32'h0);
        rd("rst_pend", 32'h4, 32'h0);
        rd("rst_cause", 32'h8, 32'h0);
        chk("rst_int", 32'(int_o), 32'h0);
        chk("rst_iout", iout, 32'h0);

        // basic grant
        wr(32'h0, 32'h5);
        rd("mask5", 32'h0, 32'h5);
        wr(32'h0, 32'hFFFF_FFFF);
        rd("mask_hi_drop", 32'h0, 32'h1FF);
        wr(32'h0, 32'h5);
        i_src[1] = 1'b1;
        tick();
        i_src[1] = 1'b0;
        rd("b_pend", 32'h4, 32'h4);
        chk("b_int0", 32'(int_o), 32'h0);
        tick();
        chk("b_int1", 32'(int_o), 32'h1);
        rd("b_cause", 32'h8, 32'h8000_0002);
        rd("b_cause_norfx", 32'h8, 32'h8000_0002);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("b_ack", 32'(int_o), 32'h0);
        rd("b_svc_cause", 32'h8, 32'h8000_0002);
        rd("eoi_rd", 32'hC, 32'h0);
        wr(32'hC, 32'h0);
        rd("b_eoi_pend", 32'h4, 32'h0);
        rd("b_eoi_cause", 32'h8, 32'h0000_0002);
        chk("b_eoi_int", 32'(int_o), 32'h0);

        // priority: IDs 1 and 4 together
        wr(32'h0, 32'h1F);
        i_src = 8'h09;
        tick();
        i_src = '0;
        rd("p_pend", 32'h4, 32'h12);
        tick();
        chk("p_int1", 32'(int_o), 32'h1);
        rd("p_cause1", 32'h8, 32'h8000_0001);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        wr(32'hC, 32'h0);
        rd("p_pend2", 32'h4, 32'h10);
        chk("p_gap", 32'(int_o), 32'h0);
        tick();
        chk("p_int2", 32'(int_o), 32'h1);
        rd("p_cause2", 32'h8, 32'h8000_0004);
        wr(32'hC, 32'h0);
        chk("p_eoi_in_req", 32'(int_o), 32'h1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        wr(32'hC, 32'h0);
        rd("p_pend3", 32'h4, 32'h0);

        // masked source
        wr(32'h0, 32'h1);
        i_src[1] = 1'b1;
        tick();
        rd("m_pend", 32'h4, 32'h4);
        tick();
        chk("m_int0", 32'(int_o), 32'h0);
        i_src[1] = 1'b0;
        wr(32'h0, 32'h5);
        chk("m_int_k", 32'(int_o), 32'h0);
        tick();
        chk("m_int_k1", 32'(int_o), 32'h1);
        rd("m_cause", 32'h8, 32'h8000_0002);

        // W1C of the selected bit while in REQ
        wr(32'h4, 32'h4);
        chk("w_int", 32'(int_o), 32'h0);
        rd("w_pend", 32'h4, 32'h0);
        rd("w_cause", 32'h8, 32'h0000_0002);
        i_src[1] = 1'b1;
        tick();
        tick();
        chk("w_req2", 32'(int_o), 32'h1);
        i_src[1] = 1'b0;
        tick();
        i_src[1] = 1'b1;
        wr(32'h4, 32'h4);
        rd("w_set_wins", 32'h4, 32'h4);
        chk("w_stay_req", 32'(int_o), 32'h1);

        // reset in SERVICE
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        i_src[2] = 1'b1;
        tick();
        rd("r_pend", 32'h4, 32'hC);
        rd("r_cause", 32'h8, 32'h8000_0002);
        i_src = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_int", 32'(int_o), 32'h0);
        rd("r_mask0", 32'h0, 32'h0);
        rd("r_pend0", 32'h4, 32'h0);
        rd("r_cause0", 32'h8, 32'h0);
        wr(32'h0, 32'h5);
        tick();
        chk("r_noint", 32'(int_o), 32'h0);
        i_src[1] = 1'b1;
        tick();
        tick();
        chk("r_newedge", 32'(int_o), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
